uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The block SHALL have parameter PRESCALE_WIDTH, default 6, giving the width of the bit-period input.
REQ-003 clk  input  1  system clock; all state changes on its rising edge; one clock domain only.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-006 Data_Valid  input  1  request to send P_DATA; sampled only while idle.
REQ-007 PAR_EN  input  1  1 = append parity bit.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 Prescale  input  PRESCALE_WIDTH  clocks per serial bit; 0 is treated as 1.
REQ-010 TX_OUT  output  1  serial line, registered, idle high.
REQ-011 Busy  output  1  registered; high from start bit through stop bit.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, TX_OUT SHALL be 1 and Busy SHALL be 0.
REQ-014 In IDLE, a rising edge with Data_Valid=1 SHALL capture P_DATA, PAR_EN, PAR_TYP and Prescale into internal registers and enter START.
REQ-015 After the accepting edge, TX_OUT SHALL be 0 and Busy SHALL be 1 in the next cycle, giving one cycle of latency from accept to start bit.
REQ-016 Each state except IDLE SHALL hold TX_OUT for exactly the captured Prescale clock cycles, counted by an internal bit-period counter.
REQ-017 Transitions SHALL be: START -> DATA; DATA -> PARITY if captured PAR_EN=1, else DATA -> STOP; PARITY -> STOP; STOP -> IDLE.
REQ-018 DATA SHALL send DATA_WIDTH bits LSB first, using a bit index counter from 0 to DATA_WIDTH-1, and SHALL leave DATA after index DATA_WIDTH-1 has completed its period.
REQ-019 The parity bit SHALL be the XOR of the captured data for even parity and the inverted XOR for odd parity.
REQ-020 STOP SHALL drive TX_OUT=1 for one bit period.
REQ-021 Busy SHALL stay 1 from the first start-bit cycle through the last stop-bit cycle.
REQ-022 A frame SHALL occupy exactly (DATA_WIDTH+2+PAR_EN)*max(Prescale,1) cycles.
REQ-023 Data_Valid SHALL be ignored while Busy=1; no request is queued.
REQ-024 Frames SHALL be accepted only in IDLE, so back-to-back requests are separated by at least one idle-high cycle (Busy=0).
REQ-025 Changes on P_DATA, PAR_EN, PAR_TYP or Prescale during a frame SHALL NOT affect that frame.
REQ-026 TX_OUT SHALL be glitch-free, driven directly from a flop.

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, TX_OUT=1, Busy=0, and clear all counters and capture registers, effective in the next cycle.
REQ-028 Reset during a frame SHALL abort it immediately, with no stop bit and no resumption.
REQ-029 rst=0 together with Data_Valid=1 SHALL NOT accept a frame; reset has priority.

Verification
REQ-030 Prescale=1, P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT 0,1,0,1,0,0,1,0,1,1 on consecutive cycles; Busy=1 for exactly 10 cycles; then idle high.
REQ-031 Prescale=1, P_DATA=0xA5, PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1; Busy=1 for 11 cycles.
REQ-032 Prescale=4, P_DATA=0x01, PAR_EN=0 -> start low for 4 cycles, bit0 high for 4 cycles, bits1-7 low for 28 cycles, stop high for 4 cycles; Busy=1 for 40 cycles. Prescale=0 SHALL give the same waveform as Prescale=1.
REQ-033 Data_Valid held at 1 with P_DATA=0x3C, and P_DATA changed to 0xFF mid-frame -> first frame carries 0x3C; exactly one Busy=0, TX_OUT=1 cycle; second frame carries 0xFF.
REQ-034 rst=0 for one edge during data bit 3 of a frame -> next cycle TX_OUT=1, Busy=0; a subsequent Data_Valid produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- parallel-to-serial UART transmitter with optional parity.
//
// Frame layout on TX_OUT, LSB first:
//   start(0) | DATA_WIDTH data bits | [parity] | stop(1)
// Every bit is held for max(Prescale,1) clock cycles.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active low
//   P_DATA      in   DATA_WIDTH   byte to transmit
//   Data_Valid  in   send request, looked at only while idle
//   PAR_EN      in   1 = append a parity bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   Prescale    in   PRESCALE_WIDTH clocks per bit (0 behaves as 1)
//   TX_OUT      out  serial line, registered, idles high
//   Busy        out  registered, high from start bit through stop bit
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                    state_q,   state_d;
  logic                      tx_q,      tx_d;
  logic                      busy_q,    busy_d;
  logic [DATA_WIDTH-1:0]     data_q,    data_d;
  logic                      par_en_q,  par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,   presc_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;

  logic             bit_done;
  logic             par_bit;
  logic [IDX_W-1:0] idx_nxt;

  // presc_q is never zero outside IDLE (zero is folded to one at capture),
  // so the subtraction cannot underflow while it matters.
  assign bit_done = (cnt_q == (presc_q - PRESCALE_WIDTH'(1)));
  assign par_bit  = (^data_q) ^ par_typ_q;
  assign idx_nxt  = idx_q + IDX_W'(1);

  // Next-state and next-output logic. TX_OUT/Busy are computed one cycle
  // ahead so they can come straight out of flops.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    cnt_d     = bit_done ? '0 : cnt_q + PRESCALE_WIDTH'(1);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        idx_d  = '0;
        if (Data_Valid) begin
          // Snapshot everything so later input changes cannot touch the frame.
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          presc_d   = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end

      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end

      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          // One mandatory IDLE cycle follows, which is where the next
          // request gets sampled.
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule
